// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP camera-emulator source.
// Holds the frame FSM states, the colour-bar palette and the counter width helper.
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_LINE,
        ST_HBLANK,
        ST_VFRONT
    } dvp_state_t;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    // Bits needed for a counter running 0 .. n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_colorbar.sv
// Eight-bar RGB565 test pattern; pixel for column x appears one cycle after x,
// matching the read latency of the upstream pixel FIFO.
module dvp_colorbar
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int XW       = cnt_width(H_ACTIVE)
) (
    input  logic          sclk,
    input  logic          s_rst,
    input  logic [XW-1:0] x,
    output logic [15:0]   pix
);

    logic [31:0] x8;
    logic [2:0]  idx;
    logic [15:0] pix_d;
    logic [15:0] pix_q;

    // Bar index = floor(x*8/H_ACTIVE), found by counting thresholds passed.
    always_comb begin
        x8  = 32'(x) << 3;
        idx = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (x8 >= k * 32'(H_ACTIVE)) begin
                idx = idx + 3'd1;
            end
        end
        pix_d = bar_color(idx);
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign pix = pix_q;

endmodule

// File: rtl/dvp_tx.sv
// OV5640-style DVP source: frame/line timing FSM, FIFO fetch control and
// high-byte-first RGB565 serialiser, with an optional colour-bar pattern.
module dvp_tx
    import dvp_pkg::*;
#(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_BLANK   = 160,
    parameter int   V_ACTIVE  = 480,
    parameter int   VSYNC_LEN = 8,
    parameter int   V_BACK    = 32,
    parameter int   V_FRONT   = 32,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic        sclk,
    input  logic        s_rst,
    input  logic        en,
    input  logic        test_mode,
    output logic        pix_rd_en,
    input  logic [15:0] pix_data,
    input  logic        pix_empty,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_done,
    output logic        underflow
);

    localparam int CM1  = (H_BLANK > V_BACK) ? H_BLANK : V_BACK;
    localparam int CM2  = (V_FRONT > VSYNC_LEN) ? V_FRONT : VSYNC_LEN;
    localparam int CMAX = (CM1 > CM2) ? CM1 : CM2;

    localparam int unsigned XW = cnt_width(H_ACTIVE);
    localparam int unsigned YW = cnt_width(V_ACTIVE);
    localparam int unsigned CW = cnt_width(CMAX);

    localparam logic [CW-1:0] VS_LAST  = CW'(VSYNC_LEN - 1);
    localparam logic [CW-1:0] VB_LAST  = CW'(V_BACK - 1);
    localparam logic [CW-1:0] VB_FETCH = CW'(V_BACK - 2);
    localparam logic [CW-1:0] HB_LAST  = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] HB_FETCH = CW'(H_BLANK - 2);
    localparam logic [CW-1:0] VF_LAST  = CW'(V_FRONT - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);

    generate
        if (H_BLANK < 2 || V_BACK < 2) begin : g_param_check
            $error("dvp_tx: H_BLANK and V_BACK must both be at least 2");
        end
    endgenerate

    dvp_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          ph_q, ph_d;
    logic          mode_q, mode_d;
    logic [7:0]    lo_q, lo_d;
    logic          empty_q, empty_d;
    logic          rd_en_q, rd_en_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          uf_q, uf_d;

    logic [XW-1:0] bar_x;
    logic [15:0]   bar_pix;
    logic [15:0]   pix_word;

    // The pixel fetched in this cycle: column 0 from blanking, else the next column.
    assign bar_x = (state_q == ST_LINE) ? x_q + XW'(1) : '0;

    dvp_colorbar #(
        .H_ACTIVE (H_ACTIVE),
        .XW       (XW)
    ) u_bars (
        .sclk  (sclk),
        .s_rst (s_rst),
        .x     (bar_x),
        .pix   (bar_pix)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        ph_d    = ph_q;
        mode_d  = mode_q;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_VSYNC;
                    mode_d  = test_mode;
                end
            end
            ST_VSYNC: begin
                if (cnt_q == VS_LAST) begin
                    state_d = ST_VBACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_VBACK: begin
                if (cnt_q == VB_LAST) begin
                    state_d = ST_LINE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LINE: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    if (x_q == X_LAST) begin
                        state_d = ST_HBLANK;
                        x_d     = '0;
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            ST_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    if (y_q == Y_LAST) begin
                        state_d = ST_VFRONT;
                        y_d     = '0;
                    end else begin
                        state_d = ST_LINE;
                        y_d     = y_q + YW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_VFRONT: begin
                if (cnt_q == VF_LAST) begin
                    cnt_d = '0;
                    if (en) begin
                        state_d = ST_VSYNC;
                        mode_d  = test_mode;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from next-state values so the registers line up with state_q.
        rd_en_d = ~mode_d &
                  (((state_d == ST_VBACK)  && (cnt_d == VB_FETCH)) ||
                   ((state_d == ST_HBLANK) && (cnt_d == HB_FETCH) && (y_d != Y_LAST)) ||
                   ((state_d == ST_LINE)   && !ph_d && (x_d != X_LAST)));

        empty_d  = rd_en_q ? pix_empty : empty_q;
        uf_d     = uf_q | (rd_en_q & pix_empty);
        pix_word = mode_q ? bar_pix : (empty_q ? 16'h0000 : pix_data);

        lo_d   = lo_q;
        data_d = '0;
        if (state_d == ST_LINE) begin
            if (ph_d) begin
                data_d = lo_q;
            end else begin
                data_d = pix_word[15:8];
                lo_d   = pix_word[7:0];
            end
        end

        vsync_d = (state_d == ST_VSYNC) ? VSYNC_POL : ~VSYNC_POL;
        href_d  = (state_d == ST_LINE);
        done_d  = (state_d == ST_VFRONT) && (cnt_d == VF_LAST);
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ph_q    <= 1'b0;
            mode_q  <= 1'b0;
            lo_q    <= '0;
            empty_q <= 1'b0;
            rd_en_q <= 1'b0;
            vsync_q <= ~VSYNC_POL;
            href_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ph_q    <= ph_d;
            mode_q  <= mode_d;
            lo_q    <= lo_d;
            empty_q <= empty_d;
            rd_en_q <= rd_en_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            done_q  <= done_d;
            uf_q    <= uf_d;
        end
    end

    assign pix_rd_en  = rd_en_q;
    assign dvp_vsync  = vsync_q;
    assign dvp_href   = href_q;
    assign dvp_data   = data_q;
    assign frame_done = done_q;
    assign underflow  = uf_q;

endmodule
